led_seq_ctrl: RTL and testbench
===============================

// Module: led_seq_ctrl
// PURPOSE
//   Sequencing controller for the LED datapath. Consumes the rate tick from the
//   count block and the user switches, then selects and advances an LED pattern mode.
//   Routes the resulting pattern to the red, blue or green LED bank.
//   Sits in top between u_count (tick source) and the board LED pins.
// PARAMETERS
//   NB_LED        5   LED bank width (>=2)
//   NB_MODE       2   mode-select width (fixed, 4 modes)
//   DEBOUNCE_CYC  4   stable cycles required per switch change (SW_DEBOUNCE_EN only)
// PORTS
//   clock    in   1       system clock, all state on rising edge
//   i_reset  in   1       asynchronous, active-low reset
//   i_valid  in   1       1-cycle rate tick from count
//   i_sw     in   4       [0] run, [2:1] mode request, [3] unused (reserved)
//   i_color  in   2       00 red, 01 blue, 10 green, 11 all banks
//   o_led    out  NB_LED  red bank
//   o_led_b  out  NB_LED  blue bank
//   o_led_g  out  NB_LED  green bank
//   o_mode   out  2       mode currently applied
//   o_busy   out  1       mode change pending (requested != applied)
// BEHAVIOUR
//   Reset (async, i_reset=0): pat=0..01, dir=left, o_mode=00, FSM=IDLE, o_busy=0,
//     all LED outputs 0. Release is synchronous to clock.
//   Modes (advance only on i_valid while RUN):
//     00 SHL   rotate left  (init 0..01); 10000 -> 00001 wrap
//     01 SHR   rotate right (init 10..0); 00001 -> 10000 wrap
//     10 PING  single bit bounce (init 0..01, dir left); at MSB dir flips on the
//          same tick, e.g. 01000,10000,01000; at LSB it flips back to left
//     11 FLASH toggles all-ones/all-zeros (init all-ones)
//   FSM states: IDLE, RUN, PEND.
//     IDLE: run=0. pat frozen and still displayed. A mode request loads the init
//       pattern on the next edge (no tick needed).
//     RUN: run=1. Each i_valid advances pat. If i_sw[2:1]!=o_mode, go to PEND.
//     PEND: o_busy=1. The next i_valid applies the new mode and loads the init
//       pattern (no shift on that tick), then returns to RUN. run=0 goes to IDLE
//       and applies the mode at once.
//   Simultaneous events:
//     - tick + mode change in the same cycle: the change is applied on that tick.
//     - tick + run falling: tick ignored.
//     - request reverts to o_mode while in PEND: drop to RUN, pattern unchanged.
//   Latency: i_valid sampled at edge k -> pat and LED outputs valid after edge k.
//     i_color change -> outputs after the next edge. Outputs are registered.
//   Color routing: unselected banks driven 0. 11 drives pat on all three banks.
//   Reset mid-sequence: immediate clear; restart at SHL 0..01.
// CONFIGURATION
//   SW_DEBOUNCE_EN defined: i_sw and i_color pass a 2-FF synchronizer, then a
//     DEBOUNCE_CYC stable filter. Glitches shorter than DEBOUNCE_CYC are ignored.
//     Added input latency is 2+DEBOUNCE_CYC cycles.
//   SW_DEBOUNCE_EN undefined: i_sw and i_color are synchronous and used directly.
//     No extra latency.
// STRUCTURE
//   Package led_ctrl_pkg: MODE_SHL/SHR/PING/FLASH, state encodings
//     ST_IDLE/ST_RUN/ST_PEND, COLOR_R/B/G/ALL codes, init-pattern functions
//     parameterised by NB_LED.
//   Sub-module sw_debounce (width and DEBOUNCE_CYC parameters); instantiated
//     only under SW_DEBOUNCE_EN.
// TESTING
//   1 reset low mid-run -> all LEDs 0, o_mode=00 at once; after release,
//     first tick gives 00010.
//   2 run=1, mode=00, color=00, 6 ticks -> o_led 00010,00100,01000,10000,00001,00010;
//     o_led_b=o_led_g=0.
//   3 mode=10, 9 ticks from 00001 -> 00010,00100,01000,10000,01000,00100,00010,00001,00010.
//   4 mode 00->11 with no tick -> o_busy=1 and pat held; next tick gives 11111,
//     o_mode=11, o_busy=0; the following tick gives 00000.
//   5 tick coincident with run falling -> pat unchanged; in IDLE, mode=01 loads
//     10000 within 1 cycle.
//   6 color=11 -> all banks equal pat. With SW_DEBOUNCE_EN, a 2-cycle i_sw glitch
//     does not change mode.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// led_ctrl_pkg
//   Shared constants and helpers for the LED sequencing controller.
//   - Mode codes (MODE_SHL/SHR/PING/FLASH) as seen on the mode-request switches
//   - FSM state encodings (ST_IDLE/ST_RUN/ST_PEND)
//   - Colour routing codes (COLOR_R/B/G/ALL)
//   - init_pat(): start pattern of a mode for an LED bank of nb bits
//   No ports (package).
// ---------------------------------------------------------------------------
package led_ctrl_pkg;

  localparam logic [1:0] MODE_SHL   = 2'b00;
  localparam logic [1:0] MODE_SHR   = 2'b01;
  localparam logic [1:0] MODE_PING  = 2'b10;
  localparam logic [1:0] MODE_FLASH = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_PEND = 2'b10;

  localparam logic [1:0] COLOR_R   = 2'b00;
  localparam logic [1:0] COLOR_B   = 2'b01;
  localparam logic [1:0] COLOR_G   = 2'b10;
  localparam logic [1:0] COLOR_ALL = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Widest LED bank the init helper can describe; callers slice the low bits.
  localparam int PAT_MAX_W = 32;
  typedef logic [PAT_MAX_W-1:0] pat_max_t;

  // Decoded view of the user switches.
  typedef struct packed {
    logic       spare;
    logic [1:0] req;
    logic       run;
  } sw_req_t;

  // Start pattern of a mode for an nb-bit bank (nb < PAT_MAX_W).
  function automatic pat_max_t init_pat(input logic [1:0] mode, input int nb);
    pat_max_t ones;
    ones = '1;
    case (mode)
      MODE_SHR:   init_pat = pat_max_t'(1) << (nb - 1);
      MODE_FLASH: init_pat = ones >> (PAT_MAX_W - nb);
      default:    init_pat = pat_max_t'(1);
    endcase
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// ---------------------------------------------------------------------------
// sw_debounce
//   Two-flop synchronizer followed by a stability filter. The output follows
//   the synchronized input only after it has held the same value for
//   DEBOUNCE_CYC consecutive cycles; shorter glitches never reach the output.
//   Used by led_seq_ctrl only when SW_DEBOUNCE_EN is defined.
// Ports:
//   clk    in   1      system clock
//   rst_n  in   1      asynchronous active-low reset
//   din    in   WIDTH  raw asynchronous inputs
//   dout   out  WIDTH  synchronized, debounced inputs
// ---------------------------------------------------------------------------
module sw_debounce #(
  parameter int WIDTH        = 6,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYC - 1);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;
  logic [WIDTH-1:0] held_p2;
  logic [CNT_W-1:0] cnt;

  // Stage p0/p1: metastability synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: any change restarts the stability count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_p2 <= '0;
      cnt     <= '0;
      dout    <= '0;
    end else begin
      if (sync_p1 != held_p2) begin
        held_p2 <= sync_p1;
        cnt     <= '0;
      end else if (cnt != CNT_DONE) begin
        cnt <= cnt + 1'b1;
      end
      if (sync_p1 == held_p2 && cnt == CNT_DONE) begin
        dout <= held_p2;
      end
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// ---------------------------------------------------------------------------
// led_seq_ctrl
//   LED pattern sequencer. Advances the selected pattern mode on each rate
//   tick while running, handles mode-change requests through a small
//   IDLE/RUN/PEND FSM and routes the pattern to the red, blue or green bank.
//   Optional build macro: SW_DEBOUNCE_EN -- synchronize and debounce i_sw and
//   i_color through sw_debounce (adds input latency). Undefined: switches are
//   assumed synchronous and used directly.
// Ports:
//   clock    in   1       system clock, rising edge
//   i_reset  in   1       asynchronous active-low reset
//   i_valid  in   1       one-cycle rate tick
//   i_sw     in   4       [0] run, [2:1] mode request, [3] reserved
//   i_color  in   2       00 red, 01 blue, 10 green, 11 all banks
//   o_led    out  NB_LED  red bank
//   o_led_b  out  NB_LED  blue bank
//   o_led_g  out  NB_LED  green bank
//   o_mode   out  NB_MODE mode currently applied
//   o_busy   out  1       mode change waiting for the next tick
// ---------------------------------------------------------------------------
module led_seq_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int NB_LED       = 5,
  parameter int NB_MODE      = 2,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [3:0]         i_sw,
  input  logic [1:0]         i_color,
  output logic [NB_LED-1:0]  o_led,
  output logic [NB_LED-1:0]  o_led_b,
  output logic [NB_LED-1:0]  o_led_g,
  output logic [NB_MODE-1:0] o_mode,
  output logic               o_busy
);

  logic [3:0] sw_use;
  logic [1:0] color_use;

`ifdef SW_DEBOUNCE_EN
  logic [5:0] in_raw;
  logic [5:0] in_clean;

  assign in_raw = {i_color, i_sw};

  sw_debounce #(
    .WIDTH        (6),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_sw_debounce (
    .clk   (clock),
    .rst_n (i_reset),
    .din   (in_raw),
    .dout  (in_clean)
  );

  assign sw_use    = in_clean[3:0];
  assign color_use = in_clean[5:4];
`else
  localparam int unused_debounce_cyc = DEBOUNCE_CYC;

  assign sw_use    = i_sw;
  assign color_use = i_color;
`endif

  sw_req_t sw_req;
  assign sw_req = sw_req_t'(sw_use);

  logic               run;
  logic [NB_MODE-1:0] req;
  logic               unused_sw_spare;

  assign run             = sw_req.run;
  assign req             = sw_req.req;
  assign unused_sw_spare = sw_req.spare;

  // Architectural state
  logic [1:0]         state_q, state_d;
  logic [NB_LED-1:0]  pat_q, pat_d;
  logic               dir_q, dir_d;
  logic [NB_MODE-1:0] mode_q, mode_d;

  // Start pattern for the requested mode
  pat_max_t          init_full;
  logic [NB_LED-1:0] init_val;
  logic              unused_init_hi;

  assign init_full      = init_pat(req, NB_LED);
  assign init_val       = init_full[NB_LED-1:0];
  assign unused_init_hi = ^init_full[PAT_MAX_W-1:NB_LED];

  // A differing request takes effect at once when stopped (or just leaving
  // IDLE), or on a tick while running; otherwise it waits in PEND.
  logic mismatch;
  logic apply;

  assign mismatch = (req != mode_q);
  assign apply    = mismatch && (!run || i_valid || state_q == ST_IDLE);

  function automatic logic [NB_LED-1:0] bank(input logic [1:0]        color,
                                             input logic [1:0]        sel,
                                             input logic [NB_LED-1:0] pat);
    return (color == sel || color == COLOR_ALL) ? pat : '0;
  endfunction

  always_comb begin
    pat_d   = pat_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    state_d = state_q;

    if (apply) begin
      mode_d = req;
      pat_d  = init_val;
      dir_d  = DIR_LEFT;
    end else if (run && i_valid) begin
      case (mode_q)
        MODE_SHL: pat_d = {pat_q[NB_LED-2:0], pat_q[NB_LED-1]};
        MODE_SHR: pat_d = {pat_q[0], pat_q[NB_LED-1:1]};
        MODE_PING: begin
          // Direction flips on the same tick the bit lands on an end.
          if (dir_q == DIR_LEFT) begin
            pat_d = pat_q << 1;
            if (pat_q[NB_LED-2]) dir_d = DIR_RIGHT;
          end else begin
            pat_d = pat_q >> 1;
            if (pat_q[1]) dir_d = DIR_LEFT;
          end
        end
        default: pat_d = ~pat_q;
      endcase
    end

    if (!run) begin
      state_d = ST_IDLE;
    end else if (mismatch && !apply) begin
      state_d = ST_PEND;
    end else begin
      state_d = ST_RUN;
    end
  end

  // Registered state and outputs; LED banks show the post-edge pattern.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      pat_q   <= NB_LED'(1);
      dir_q   <= DIR_LEFT;
      mode_q  <= MODE_SHL;
      o_led   <= '0;
      o_led_b <= '0;
      o_led_g <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      o_led   <= bank(color_use, COLOR_R, pat_d);
      o_led_b <= bank(color_use, COLOR_B, pat_d);
      o_led_g <= bank(color_use, COLOR_G, pat_d);
    end
  end

  assign o_mode = mode_q;
  assign o_busy = (state_q == ST_PEND);

endmodule

// File: tb/tb_led_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_seq_ctrl
//   Self-checking bench for led_seq_ctrl (default build). Directed steps plus
//   a randomized run, all compared against a behavioural model that tracks
//   the lit-bit position, bounce direction and flash phase.
// ---------------------------------------------------------------------------
module tb_led_seq_ctrl;

  localparam int NB = 5;

  logic          clock = 1'b0;
  logic          i_reset;
  logic          i_valid;
  logic [3:0]    i_sw;
  logic [1:0]    i_color;
  logic [NB-1:0] o_led;
  logic [NB-1:0] o_led_b;
  logic [NB-1:0] o_led_g;
  logic [1:0]    o_mode;
  logic          o_busy;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int m_mode;
  int m_pos;
  int m_left;
  int m_on;
  int m_prev_run;
  int m_busy;

  led_seq_ctrl #(
    .NB_LED       (NB),
    .NB_MODE      (2),
    .DEBOUNCE_CYC (4)
  ) dut (
    .clock   (clock),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .i_sw    (i_sw),
    .i_color (i_color),
    .o_led   (o_led),
    .o_led_b (o_led_b),
    .o_led_g (o_led_g),
    .o_mode  (o_mode),
    .o_busy  (o_busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode     = 0;
    m_pos      = 0;
    m_left     = 1;
    m_on       = 1;
    m_prev_run = 0;
    m_busy     = 0;
  endtask

  function automatic int model_pat();
    if (m_mode == 3) return m_on ? ((1 << NB) - 1) : 0;
    return 1 << m_pos;
  endfunction

  task automatic model_step(input bit v, input logic [3:0] sw);
    bit run;
    int req;
    run = sw[0];
    req = int'(sw[2:1]);
    if (req != m_mode && (!run || v || !m_prev_run)) begin
      m_mode = req;
      m_pos  = (req == 1) ? NB - 1 : 0;
      m_left = 1;
      m_on   = 1;
    end else if (run && v) begin
      case (m_mode)
        0: m_pos = (m_pos + 1) % NB;
        1: m_pos = (m_pos + NB - 1) % NB;
        2: begin
          m_pos = m_left ? m_pos + 1 : m_pos - 1;
          if (m_pos == NB - 1) m_left = 0;
          if (m_pos == 0) m_left = 1;
        end
        default: m_on = !m_on;
      endcase
    end
    m_prev_run = run;
    m_busy     = (run && req != m_mode) ? 1 : 0;
  endtask

  // One clock with the given inputs, then compare every output to the model.
  task automatic step(input bit v, input logic [3:0] sw, input logic [1:0] col);
    int p;
    i_valid = v;
    i_sw    = sw;
    i_color = col;
    @(posedge clock);
    #1;
    model_step(v, sw);
    p = model_pat();
    check("led_r", 32'(o_led),   (col == 2'd0 || col == 2'd3) ? p : 0);
    check("led_b", 32'(o_led_b), (col == 2'd1 || col == 2'd3) ? p : 0);
    check("led_g", 32'(o_led_g), (col == 2'd2 || col == 2'd3) ? p : 0);
    check("mode",  32'(o_mode),  m_mode);
    check("busy",  32'(o_busy),  m_busy);
  endtask

  initial begin
    logic [NB-1:0] t2_exp [6];
    logic [NB-1:0] t3_exp [9];
    bit            v;
    logic [3:0]    sw;
    logic [1:0]    col;

    t2_exp = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001, 5'b00010};
    t3_exp = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b01000,
               5'b00100, 5'b00010, 5'b00001, 5'b00010};

    i_reset = 1'b0;
    i_valid = 1'b0;
    i_sw    = 4'b0000;
    i_color = 2'b00;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("rst_led_r", 32'(o_led),   0);
    check("rst_led_b", 32'(o_led_b), 0);
    check("rst_led_g", 32'(o_led_g), 0);
    check("rst_mode",  32'(o_mode),  0);
    check("rst_busy",  32'(o_busy),  0);
    i_reset = 1'b1;

    // Rotate left, red bank
    step(1'b0, 4'b0001, 2'b00);
    check("t2_start", 32'(o_led), 32'(5'b00001));
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 4'b0001, 2'b00);
      check("t2_led", 32'(o_led), 32'(t2_exp[i]));
      check("t2_b0",  32'(o_led_b), 0);
      check("t2_g0",  32'(o_led_g), 0);
    end

    // Ping-pong: select in IDLE, then tick while running
    step(1'b0, 4'b0100, 2'b00);
    check("t3_init", 32'(o_led), 32'(5'b00001));
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 4'b0101, 2'b00);
      check("t3_led", 32'(o_led), 32'(t3_exp[i]));
    end

    // Pending change to FLASH, all banks
    step(1'b0, 4'b0000, 2'b00);
    step(1'b1, 4'b0001, 2'b00);
    check("t4_pre", 32'(o_led), 32'(5'b00010));
    step(1'b0, 4'b0111, 2'b11);
    check("t4_busy",  32'(o_busy), 1);
    check("t4_hold",  32'(o_led),  32'(5'b00010));
    check("t4_mode0", 32'(o_mode), 0);
    step(1'b1, 4'b0111, 2'b11);
    check("t4_flash1", 32'(o_led),  32'(5'b11111));
    check("t4_mode3",  32'(o_mode), 3);
    check("t4_idle",   32'(o_busy), 0);
    step(1'b1, 4'b0111, 2'b11);
    check("t4_flash0", 32'(o_led), 0);
    step(1'b1, 4'b0111, 2'b11);

    // Reset mid-run
    #2;
    i_reset = 1'b0;
    #1;
    check("t1_led_r", 32'(o_led),   0);
    check("t1_led_b", 32'(o_led_b), 0);
    check("t1_led_g", 32'(o_led_g), 0);
    check("t1_mode",  32'(o_mode),  0);
    check("t1_busy",  32'(o_busy),  0);
    @(posedge clock);
    #1;
    i_reset = 1'b1;
    model_reset();
    step(1'b1, 4'b0001, 2'b00);
    check("t1_first", 32'(o_led), 32'(5'b00010));

    // Tick with run falling, then mode select in IDLE
    step(1'b1, 4'b0000, 2'b00);
    check("t5_frozen", 32'(o_led), 32'(5'b00010));
    step(1'b0, 4'b0010, 2'b00);
    check("t5_shr", 32'(o_led), 32'(5'b10000));
    step(1'b0, 4'b0011, 2'b00);
    step(1'b0, 4'b0001, 2'b00);
    check("t5_pend", 32'(o_busy), 1);
    step(1'b0, 4'b0011, 2'b00);
    check("t5_revert", 32'(o_busy), 0);
    check("t5_keep",   32'(o_led),  32'(5'b10000));
    step(1'b1, 4'b0011, 2'b00);
    check("t5_shr1", 32'(o_led), 32'(5'b01000));
    step(1'b1, 4'b0111, 2'b00);
    check("t5_tickchg", 32'(o_led), 32'(5'b11111));

    // Colour routing
    step(1'b0, 4'b0111, 2'b11);
    check("t6_all_b", 32'(o_led_b), 32'(5'b11111));
    check("t6_all_g", 32'(o_led_g), 32'(5'b11111));
    step(1'b0, 4'b0111, 2'b01);
    check("t6_blue", 32'(o_led_b), 32'(5'b11111));
    check("t6_nred", 32'(o_led),   0);
    step(1'b0, 4'b0111, 2'b10);
    check("t6_green", 32'(o_led_g), 32'(5'b11111));

    // Randomized run
    sw  = 4'b0001;
    col = 2'b00;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) sw[0] = ~sw[0];
      if ($urandom_range(0, 5) == 0) sw[2:1] = 2'($urandom_range(0, 3));
      sw[3] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) col = 2'($urandom_range(0, 3));
      step(v, sw, col);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
